// File: rtl/pheap_feeder.sv
// pheap_feeder: round-robin ingress, staging FIFO and paced enq/deq issue in front of the pipelined event heap.
// Optional macro PHEAP_FEEDER_BYPASS_EN: a lone staged event goes straight to a waiting consumer when the heap is empty.
`timescale 1ns/1ps
module pheap_feeder #(
    parameter int WIDTH      = 32,
    parameter int N_SRC      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_SRC-1:0]               src_valid,
    input  logic [N_SRC*WIDTH-1:0]         src_data,
    output logic [N_SRC-1:0]               src_ready,
    input  logic                           deq_req,
    output logic                           deq_vld,
    output logic [WIDTH-1:0]               deq_data,
    output logic                           hp_enq,
    output logic                           hp_deq,
    output logic [WIDTH-1:0]               hp_data,
    input  logic [WIDTH-1:0]               hp_out_data,
    input  logic                           hp_full,
    input  logic                           hp_empty,
    input  logic [CNT_W-1:0]               hp_cnt,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_cnt,
    output logic                           busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic {S_IDLE, S_GAP} state_t;

    state_t           r_state, w_state_nxt;
    logic [PW-1:0]    r_ptr, w_gidx, w_cand, w_ptr_nxt;
    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_cnt;
    logic [WIDTH-1:0] w_src [N_SRC];
    logic             w_found, w_accept, w_fifo_full, w_fifo_empty;
    logic             w_enq, w_deq, w_byp, w_pop;
    logic             w_unused_cnt;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign w_src[g] = src_data[g*WIDTH +: WIDTH];
    end

    // Heap element count is status only; nothing here depends on it.
    assign w_unused_cnt = ^hp_cnt;

    assign w_fifo_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
    assign w_fifo_empty = (r_cnt == '0);

    // First valid source at or after the RR pointer, wrapping.
    always_comb begin
        w_gidx  = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % N_SRC);
            if (!w_found && src_valid[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    assign w_accept  = w_found && !w_fifo_full && rst_n;
    assign src_ready = w_accept ? (N_SRC'(1) << w_gidx) : '0;
    assign w_ptr_nxt = (w_gidx == PW'(N_SRC - 1)) ? '0 : w_gidx + PW'(1);

    always_comb begin
        w_enq       = 1'b0;
        w_deq       = 1'b0;
        w_byp       = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fifo_full && !hp_full) begin
                    w_enq = 1'b1;
                end
`ifdef PHEAP_FEEDER_BYPASS_EN
                else if (deq_req && hp_empty && r_cnt == (AW+1)'(1) && src_valid == '0) begin
                    w_byp = 1'b1;
                end
`endif
                else if (deq_req && !hp_empty) begin
                    w_deq = 1'b1;
                end
                else if (!w_fifo_empty && !hp_full) begin
                    w_enq = 1'b1;
                end
                if (w_enq || w_deq) w_state_nxt = S_GAP;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (!rst_n) begin
            w_enq = 1'b0;
            w_deq = 1'b0;
            w_byp = 1'b0;
        end
    end

    assign w_pop    = w_enq || w_byp;
    assign hp_enq   = w_enq;
    assign hp_deq   = w_deq;
    assign hp_data  = r_mem[r_rp];
    assign deq_vld  = w_deq || w_byp;
    assign fifo_cnt = r_cnt;
    assign busy     = !w_fifo_empty || (r_state == S_GAP);

    always_comb begin
        deq_data = '0;
        if (w_byp)      deq_data = r_mem[r_rp];
        else if (w_deq) deq_data = hp_out_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mem[r_wp] <= w_src[w_gidx];
                r_wp        <= r_wp + AW'(1);
                r_ptr       <= w_ptr_nxt;
            end
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + {{AW{1'b0}}, w_accept} - {{AW{1'b0}}, w_pop};
        end
    end
endmodule
